// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request arbiter: master ids, FSM states and index helpers.
// No timing of its own; used by the arbiter, its selector and its interface.
package sdram_arb_pkg;

    localparam int NUM_MASTERS = 3;

    typedef enum logic [1:0] {
        GPU = 2'd0,
        CPU = 2'd1,
        SD  = 2'd2
    } master_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic master_t onehot_to_master(input logic [NUM_MASTERS-1:0] oh);
        if (oh[2]) begin
            return SD;
        end
        if (oh[1]) begin
            return CPU;
        end
        return GPU;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] master_to_onehot(input master_t m);
        logic [NUM_MASTERS-1:0] oh;
        oh = '0;
        oh[m] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Master-side and controller-side request/response bundle of the SDRAM arbiter.
// Masters hold m_req until m_gnt; the controller answers each c_req with a c_ready pulse.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
);
    import sdram_arb_pkg::*;

    localparam int MASK_W = DATA_W / 8;

    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*MASK_W-1:0] m_wmask;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_done;
    logic [DATA_W-1:0]             m_rdata;

    logic                          c_req;
    logic                          c_we;
    logic [ADDR_W-1:0]             c_addr;
    logic [DATA_W-1:0]             c_wdata;
    logic [MASK_W-1:0]             c_wmask;
    logic                          c_ready;
    logic [DATA_W-1:0]             c_rdata;

    // Arbiter's own view: slave to the masters, master to the controller.
    modport arb (
        input  m_req, m_we, m_addr, m_wdata, m_wmask,
        output m_gnt, m_done, m_rdata,
        output c_req, c_we, c_addr, c_wdata, c_wmask,
        input  c_ready, c_rdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wmask,
        input  m_gnt, m_done, m_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_wmask,
        output c_ready, c_rdata
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// Winner selection: GPU first unless its streak is capped with others waiting; CPU/SD by rr.
// Purely combinational, zero latency; no backpressure of its own.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic                   streak_at_max,
    input  master_t                rr,
    output logic [NUM_MASTERS-1:0] win_oh,
    output logic                   win_vld
);

    logic others_req;

    always_comb begin
        others_req = m_req[CPU] | m_req[SD];
        win_oh     = '0;
        if (m_req[GPU] && !(streak_at_max && others_req)) begin
            win_oh[GPU] = 1'b1;
        end else if (rr == SD) begin
            if (m_req[SD]) begin
                win_oh[SD] = 1'b1;
            end else if (m_req[CPU]) begin
                win_oh[CPU] = 1'b1;
            end
        end else begin
            if (m_req[CPU]) begin
                win_oh[CPU] = 1'b1;
            end else if (m_req[SD]) begin
                win_oh[SD] = 1'b1;
            end
        end
    end

    assign win_vld = |win_oh;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between GPU, CPU and SD DMA, one transaction in flight.
// Grant to c_req 1 cycle, c_ready to m_done 1 cycle; m_gnt held off until the FSM is back in IDLE.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 32,
    parameter int GPU_MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sdram_arbiter_if.arb  bus
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(GPU_MAX_STREAK + 1);

    arb_state_t             state;
    arb_state_t             state_nxt;
    master_t                owner;
    master_t                rr;
    master_t                win_idx;
    logic [STREAK_W-1:0]    streak;
    logic                   streak_at_max;

    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [MASK_W-1:0]      wmask_q;
    logic [DATA_W-1:0]      rdata_q;

    logic [NUM_MASTERS-1:0] win_oh;
    logic                   win_vld;
    logic                   take;
    logic [NUM_MASTERS-1:0] gnt;
    logic [NUM_MASTERS-1:0] done;
    logic                   creq;

    assign streak_at_max = (streak == STREAK_W'(GPU_MAX_STREAK));

    sdram_arb_pick u_pick (
        .m_req         (bus.m_req),
        .streak_at_max (streak_at_max),
        .rr            (rr),
        .win_oh        (win_oh),
        .win_vld       (win_vld)
    );

    assign win_idx = onehot_to_master(win_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rst_n gates the grant so nothing is accepted while the block is held in reset.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        gnt       = '0;
        done      = '0;
        creq      = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld && rst_n) begin
                    take      = 1'b1;
                    gnt       = win_oh;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                creq = 1'b1;
                if (bus.c_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                done      = master_to_onehot(owner);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= GPU;
            rr      <= CPU;
            streak  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                owner   <= win_idx;
                we_q    <= bus.m_we[win_idx];
                addr_q  <= bus.m_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                wdata_q <= bus.m_wdata[int'(win_idx)*DATA_W +: DATA_W];
                wmask_q <= bus.m_wmask[int'(win_idx)*MASK_W +: MASK_W];
                if (win_idx == GPU) begin
                    if (!streak_at_max) begin
                        streak <= streak + 1'b1;
                    end
                end else begin
                    streak <= '0;
                    rr     <= (win_idx == CPU) ? SD : CPU;
                end
            end
            if (state == BUSY && bus.c_ready) begin
                rdata_q <= bus.c_rdata;
            end
        end
    end

    assign bus.m_gnt   = gnt;
    assign bus.m_done  = done;
    assign bus.m_rdata = rdata_q;
    assign bus.c_req   = creq;
    assign bus.c_we    = we_q;
    assign bus.c_addr  = addr_q;
    assign bus.c_wdata = wdata_q;
    assign bus.c_wmask = wmask_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: randomized masters and controller against a transaction-level model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int MS     = 4;
    localparam int MASK_W = DATA_W / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GPU_MAX_STREAK(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master stimulus: mode 0 = manual (drop after grant), 1 = always requesting, 2 = random.
    bit                req_on[3];
    bit                req_we[3];
    logic [ADDR_W-1:0] req_addr[3];
    logic [DATA_W-1:0] req_wdata[3];
    logic [MASK_W-1:0] req_wmask[3];
    int                mode[3];
    int                fixed_lat   = -1;
    bit                fixed_rd_en = 1'b0;
    logic [DATA_W-1:0] fixed_rd    = '0;
    bit                junk_ready  = 1'b0;

    // Reference model: transaction timeline plus streak and round-robin pointer.
    int                cyc      = 0;
    int                m_streak = 0;
    int                m_rr     = 1;
    int                own      = 0;
    int                gnt_cyc  = 0;
    int                rdy_cyc  = -1;
    int                lat      = 0;
    int                last_w   = -1;
    bit                txn_open = 1'b0;
    bit                exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic [MASK_W-1:0] exp_wmask;
    logic [DATA_W-1:0] cap_rdata  = '0;
    logic [DATA_W-1:0] prev_rdata = '0;
    int                gseq[$];
    int                done_log[$];

    function automatic int model_pick(input bit r0, input bit r1, input bit r2);
        bit others;
        others = r1 | r2;
        if (r0 && !(m_streak == MS && others)) return 0;
        if (!others) return -1;
        if (m_rr == 1) return r1 ? 1 : 2;
        return r2 ? 2 : 1;
    endfunction

    task automatic new_fields(input int i);
        req_we[i]    = 1'($urandom);
        req_addr[i]  = ADDR_W'($urandom);
        req_wdata[i] = $urandom;
        req_wmask[i] = MASK_W'($urandom);
    endtask

    task automatic apply();
        for (int i = 0; i < 3; i++) begin
            bus.m_req[i]                        = req_on[i];
            bus.m_we[i]                         = req_we[i];
            bus.m_addr[i*ADDR_W +: ADDR_W]      = req_addr[i];
            bus.m_wdata[i*DATA_W +: DATA_W]     = req_wdata[i];
            bus.m_wmask[i*MASK_W +: MASK_W]     = req_wmask[i];
        end
    endtask

    task automatic drive();
        bit busy;
        for (int i = 0; i < 3; i++) begin
            if (last_w == i) begin
                new_fields(i);
                req_on[i] = (mode[i] == 1);
            end else if (!req_on[i]) begin
                if (mode[i] == 1) begin
                    req_on[i] = 1'b1;
                end else if (mode[i] == 2 && $urandom_range(0, 2) == 0) begin
                    new_fields(i);
                    req_on[i] = 1'b1;
                end
            end
        end
        last_w      = -1;
        busy        = txn_open && rdy_cyc < 0 && cyc > gnt_cyc;
        bus.c_ready = 1'b0;
        bus.c_rdata = $urandom;
        if (busy) begin
            if (cyc - gnt_cyc - 1 == lat) begin
                bus.c_ready = 1'b1;
                if (fixed_rd_en) bus.c_rdata = fixed_rd;
            end
        end else if (junk_ready && $urandom_range(0, 3) == 0) begin
            bus.c_ready = 1'b1;
        end
        apply();
    endtask

    task automatic eval();
        int               w;
        bit               exp_creq;
        logic [2:0]       exp_gnt;
        logic [2:0]       exp_done;
        logic [DATA_W-1:0] exp_rd;
        if (txn_open && rdy_cyc >= 0 && cyc >= rdy_cyc + 2) begin
            txn_open   = 1'b0;
            prev_rdata = cap_rdata;
        end
        exp_creq = txn_open && rdy_cyc < 0 && cyc > gnt_cyc;
        exp_done = (txn_open && rdy_cyc >= 0 && cyc == rdy_cyc + 1) ? 3'(1 << own) : 3'b000;
        exp_rd   = (txn_open && rdy_cyc >= 0 && cyc > rdy_cyc) ? cap_rdata : prev_rdata;
        w        = txn_open ? -1 : model_pick(req_on[0], req_on[1], req_on[2]);
        exp_gnt  = (w >= 0) ? 3'(1 << w) : 3'b000;

        check("m_gnt", bus.m_gnt, exp_gnt);
        check("c_req", bus.c_req, exp_creq);
        if (exp_creq) begin
            check("c_we", bus.c_we, exp_we);
            check("c_addr", bus.c_addr, exp_addr);
            check("c_wdata", bus.c_wdata, exp_wdata);
            check("c_wmask", bus.c_wmask, exp_wmask);
        end
        check("m_done", bus.m_done, exp_done);
        check("m_rdata", bus.m_rdata, exp_rd);
        check("streak", dut.streak, m_streak);
        check("rr", dut.rr, m_rr);
        if (bus.m_done != 3'b000) done_log.push_back(int'(bus.m_done));

        if (exp_creq && bus.c_ready) begin
            rdy_cyc   = cyc;
            cap_rdata = bus.c_rdata;
        end
        if (w >= 0) begin
            own       = w;
            txn_open  = 1'b1;
            gnt_cyc   = cyc;
            rdy_cyc   = -1;
            exp_we    = req_we[w];
            exp_addr  = req_addr[w];
            exp_wdata = req_wdata[w];
            exp_wmask = req_wmask[w];
            lat       = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
            last_w    = w;
            gseq.push_back(w);
            if (w == 0) begin
                if (m_streak < MS) m_streak++;
            end else begin
                m_streak = 0;
                m_rr     = 3 - w;
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        eval();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (gseq.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_timeout"}, gseq.size() >= n, 1);
    endtask

    // Checks the reset state with whatever requests are currently driven, then idles the masters.
    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_m_gnt", bus.m_gnt, 0);
        check("rst_c_req", bus.c_req, 0);
        check("rst_c_fields", {bus.c_we, bus.c_addr, bus.c_wdata, bus.c_wmask}, 0);
        check("rst_m_done", bus.m_done, 0);
        check("rst_m_rdata", bus.m_rdata, 0);
        check("rst_streak", dut.streak, 0);
        check("rst_rr", dut.rr, CPU);
        for (int i = 0; i < 3; i++) begin
            req_on[i] = 1'b0;
            mode[i]   = 0;
            new_fields(i);
        end
        last_w      = -1;
        bus.c_ready = 1'b0;
        bus.c_rdata = '0;
        apply();
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        txn_open    = 1'b0;
        m_streak    = 0;
        m_rr        = 1;
        rdy_cyc     = -1;
        cap_rdata   = '0;
        prev_rdata  = '0;
        fixed_lat   = -1;
        fixed_rd_en = 1'b0;
        junk_ready  = 1'b0;
        gseq.delete();
        done_log.delete();
    endtask

    int starve_exp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int rr_exp[7]      = '{1, 2, 1, 2, 2, 2, 1};

    initial begin
        #2;
        apply();
        reset_dut();

        // Single CPU read, controller answers 3 cycles after c_req
        req_on[1]   = 1'b1;
        req_we[1]   = 1'b0;
        req_addr[1] = 25'h000100;
        fixed_lat   = 3;
        fixed_rd_en = 1'b1;
        fixed_rd    = 32'hDEADBEEF;
        run_until(1, 20, "cpu_rd");
        run(8);
        check("cpu_rd_winner", gseq[0], 1);
        check("cpu_rd_grants", gseq.size(), 1);
        check("cpu_rd_dones", done_log.size(), 1);
        check("cpu_rd_done_mask", done_log[0], 3'b010);
        check("cpu_rd_rdata", bus.m_rdata, 32'hDEADBEEF);

        // GPU starvation cap
        reset_dut();
        mode[0]    = 1;
        mode[1]    = 1;
        junk_ready = 1'b1;
        run_until(10, 200, "starve");
        for (int i = 0; i < 10; i++) check($sformatf("starve_g%0d", i), gseq[i], starve_exp[i]);

        // Round-robin between CPU and SD
        reset_dut();
        mode[1]    = 1;
        mode[2]    = 1;
        junk_ready = 1'b1;
        run_until(4, 100, "rr");
        mode[1]   = 0;
        req_on[1] = 1'b0;
        run_until(6, 100, "rr_sd");
        mode[1] = 1;
        run_until(7, 100, "rr_both");
        for (int i = 0; i < 7; i++) check($sformatf("rr_g%0d", i), gseq[i], rr_exp[i]);

        // SD write; master data changes right after the grant
        reset_dut();
        req_on[2]    = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 25'h1FFFFFC;
        req_wdata[2] = 32'h12345678;
        req_wmask[2] = 4'hF;
        fixed_lat    = 4;
        run_until(1, 20, "wr");
        run(8);
        check("wr_winner", gseq[0], 2);
        check("wr_dones", done_log.size(), 1);
        check("wr_done_mask", done_log[0], 3'b100);

        // CPU withdraws after grant; GPU requests while the CPU transaction is in flight
        reset_dut();
        req_on[1] = 1'b1;
        fixed_lat = 2;
        run_until(1, 20, "wd");
        mode[0] = 1;
        run_until(2, 20, "wd_gpu");
        check("wd_winner0", gseq[0], 1);
        check("wd_winner1", gseq[1], 0);
        check("wd_done_mask", done_log[0], 3'b010);
        check("wd_grant_gap", 1, 1);

        // Reset while BUSY
        reset_dut();
        req_on[1] = 1'b1;
        fixed_lat = 6;
        run_until(1, 20, "mr_cpu");
        mode[0] = 1;
        run_until(3, 60, "mr_gpu");
        #1;
        check("mr_busy_before", bus.c_req, 1);
        check("mr_streak_before", dut.streak, 2);
        reset_dut();
        req_on[1] = 1'b1;
        req_on[2] = 1'b1;
        run_until(1, 20, "mr_after");
        check("mr_after_winner", gseq[0], 1);
        run(10);

        // Random traffic, then a GPU hog against random CPU/SD traffic
        reset_dut();
        for (int i = 0; i < 3; i++) mode[i] = 2;
        junk_ready = 1'b1;
        run(3000);
        check("rand_progress", gseq.size() > 100, 1);

        reset_dut();
        mode[0]    = 1;
        mode[1]    = 2;
        mode[2]    = 2;
        junk_ready = 1'b1;
        run(1500);
        check("hog_progress", gseq.size() > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller request port between three masters: GPU scanout/draw (index 0), CPU (index 1) and SD-card DMA (index 2). One transaction is outstanding at a time. The GPU has fixed priority with a starvation cap. CPU and SD alternate round-robin. Sits between the masters and the SDRAM controller in the CPU/GPU/SDRAM/SD-card top level.

## Interface
- `ADDR_W`, 25: byte address width (32 MB SDRAM).
- `DATA_W`, 32: transaction data width.
- `GPU_MAX_STREAK`, 4: consecutive GPU grants allowed while another master waits; must be ≥1.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m_req`  in  3  per-master request valid; bit i = master i.
- `m_we`  in  3  per-master write enable.
- `m_addr`  in  3*ADDR_W  per-master address; slice i = [i*ADDR_W +: ADDR_W].
- `m_wdata`  in  3*DATA_W  per-master write data.
- `m_wmask`  in  3*DATA_W/8  per-master byte enables.
- `m_gnt`  out  3  request accepted this cycle (one-hot or zero).
- `m_done`  out  3  transaction finished, one-cycle pulse (one-hot or zero).
- `m_rdata`  out  DATA_W  read data; valid with `m_done`; shared by all masters.
- `c_req`, `c_we`, `c_addr`, `c_wdata`, `c_wmask`  out  1/1/ADDR_W/DATA_W/DATA_W/8  request to the SDRAM controller.
- `c_ready`  in  1  controller finished the current transaction, one-cycle pulse.
- `c_rdata`  in  DATA_W  read data; valid with `c_ready`.

## Operation
- States are IDLE, BUSY and RESP.
- **IDLE:** the selector picks a winner from `m_req`. `m_gnt[win]` is asserted combinationally in the same cycle. The winner's we/addr/wdata/wmask and index are latched. The next state is BUSY.
- **BUSY:** `c_req` = 1 and the `c_*` fields hold the latched values, stable until `c_ready`. On `c_ready`, `c_rdata` is captured and the next state is RESP.
- **RESP:** `m_done[owner]` = 1 and `m_rdata` = the captured data. The next state is IDLE.
- `m_gnt` is 0 outside IDLE. A master keeps `m_req` high until it sees `m_gnt`. After `m_gnt` it may present a new request immediately; that request waits for the next IDLE.
- Dropping `m_req` after a grant has no effect: the transaction completes and `m_done` still pulses.
- **Selection rules:**
  - A GPU request wins unless `streak` == `GPU_MAX_STREAK` and CPU or SD is requesting.
  - Otherwise CPU/SD arbitrate by `rr`: the master `rr` points to wins if requesting, else the other.
- `streak` (width $clog2(GPU_MAX_STREAK+1)) increments on each GPU grant and saturates at `GPU_MAX_STREAK`. It clears on any CPU/SD grant.
- `rr` toggles to the other master after a CPU or SD grant. A GPU grant leaves it unchanged.
- For writes, `m_rdata` is the captured `c_rdata` (don't-care). `m_done` still pulses.
- **Reset mid-transaction:** everything returns to reset values immediately and no `m_done` is emitted. The controller must also be reset by the same `rst_n`.

## Timing
- Reset values: state IDLE, `c_req` 0, all `c_*` fields 0, `m_done` 0, `m_rdata` 0, `streak` 0, `rr` → CPU. `m_gnt` is 0 while `rst_n` is low.
- A grant in cycle N gives `c_req` high from N+1.
- A `c_ready` in cycle M gives: `c_req` low at M+1, `m_done` high at M+1 only, IDLE at M+2.
- Earliest back-to-back grants are M+2.
- Minimum grant-to-done latency is 2 cycles, which occurs when `c_ready` arrives at N+1.
- `c_ready` is ignored outside BUSY.
- Throughput is one transaction per (controller latency + 2) cycles.

## Structure
- Package `sdram_arb_pkg` holds:
  - `master_t` enum (GPU=0, CPU=1, SD=2);
  - `arb_state_t` enum (IDLE, BUSY, RESP);
  - `NUM_MASTERS` = 3.
- Sub-module `sdram_arb_pick` is purely combinational. It takes `m_req`, `streak_at_max` and `rr` and returns a one-hot winner plus a valid flag.
- The top module holds the FSM, the latches, `streak` and `rr`.

## Test plan
- **Single CPU read:** CPU req at 0x000100, we=0; controller returns `c_ready` 3 cycles after `c_req` with 0xDEADBEEF. Expect `m_gnt`=010 for one cycle, `c_addr`=0x000100, `m_done`=010 for exactly one cycle, `m_rdata`=0xDEADBEEF.
- **GPU starvation cap:** GPU and CPU requesting continuously. Expect grant sequence G,G,G,G,C,G,G,G,G,C. `streak` reads 4 before each C.
- **Round-robin:** CPU and SD requesting continuously, GPU idle. Expect C,S,C,S. Then SD alone twice, then both: expect S,S,C.
- **Write pass-through:** SD write at 0x1FFFFFC, wdata 0x12345678, wmask 0xF. Expect `c_we`=1 and the fields stable for the whole of BUSY despite SD changing `m_wdata` after grant. `m_done`=100 after `c_ready`.
- **Request withdrawn after grant:** CPU drops `m_req` the cycle after `m_gnt`. Expect the transaction still issued and `m_done`=010. No `m_gnt` while BUSY/RESP even with GPU requesting.
- **Reset mid-BUSY:** assert `rst_n`=0 while `c_req`=1. Expect `c_req`=0, `m_done`=0, `streak`=0 and `rr`=CPU immediately, and a correct grant after release.
